// File: rtl/score_pkg.sv
// Shared definitions for the score display scheduler.
//   MAX_DISPLAY_DEFAULT  : largest value that fits on 8 decimal digits
//   DEFAULT_*_CYCLES     : dwell/hold durations at the board clock rate
//   state_t              : scheduler FSM states
//   sat_value()          : clamps a value to a ceiling (no modulo wrap)
package score_pkg;

  localparam logic [31:0] MAX_DISPLAY_DEFAULT  = 32'd99_999_999;
  localparam int          DEFAULT_DWELL_CYCLES = 50_000_000;
  localparam int          DEFAULT_HOLD_CYCLES  = 100_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Anything above the ceiling is pinned to the ceiling.
  function automatic logic [31:0] sat_value(input logic [31:0] value,
                                            input logic [31:0] ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/rr_next_index.sv
// Round-robin search helper (purely combinational).
// Returns the first set bit of 'mask' strictly after 'cur', wrapping modulo N.
// When nothing but 'cur' itself is set, 'cur' is returned (the search wraps
// all the way round). Driving cur = N-1 yields the lowest set bit.
//   mask     : candidate bits
//   cur      : starting index (excluded until the wrap reaches it)
//   next_idx : selected index (equals cur when nothing is found)
//   found    : 1 when any bit of mask is set
module rr_next_index #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next_idx,
  output logic         found
);

  logic [N-1:0] shifted;
  int           idx;

  // Walk offsets 1..N from the current index; the first hit wins. The mask is
  // shifted rather than bit-indexed so a variable index stays width-clean.
  always_comb begin
    next_idx = cur;
    found    = 1'b0;
    idx      = 0;
    shifted  = '0;
    for (int k = 1; k <= N; k++) begin
      idx     = (int'(cur) + k) % N;
      shifted = mask >> idx;
      if (!found && shifted[0]) begin
        found    = 1'b1;
        next_idx = W'(idx);
      end
    end
  end

endmodule

// File: rtl/score_display_scheduler.sv
// Shares one 8-digit score display between N_SRC value sources.
// Enabled sources are rotated round-robin with a fixed dwell; any source can
// request an urgent hold that preempts the rotation. Each source value is
// latched into a saturating shadow register.
//   CLK, RST     : clock, synchronous active-high reset
//   SRC_EN       : level, source takes part in rotation
//   SRC_VALID    : pulse, slice i of SRC_VALUE carries a new value
//   SRC_VALUE    : N_SRC x 32-bit unsigned values
//   SRC_URGENT   : pulse, queue an urgent hold of source i
//   SRC_ACK      : one-cycle pulse the cycle after SRC_VALID[i] is latched
//   DISP_VALUE   : shown value, registered, never above MAX_DISPLAY
//   DISP_SRC     : index of the source being shown
//   DISP_VALID   : 1 while a source is shown, 0 when idle
module score_display_scheduler
  import score_pkg::*;
#(
  parameter int          N_SRC        = 3,
  parameter int          DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int          HOLD_CYCLES  = DEFAULT_HOLD_CYCLES,
  parameter logic [31:0] MAX_DISPLAY  = MAX_DISPLAY_DEFAULT,
  localparam int         SRC_W        = $clog2(N_SRC)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_SRC-1:0]     SRC_EN,
  input  logic [N_SRC-1:0]     SRC_VALID,
  input  logic [32*N_SRC-1:0]  SRC_VALUE,
  input  logic [N_SRC-1:0]     SRC_URGENT,
  output logic [N_SRC-1:0]     SRC_ACK,
  output logic [31:0]          DISP_VALUE,
  output logic [SRC_W-1:0]     DISP_SRC,
  output logic                 DISP_VALID
);

  localparam int CNT_MAX = (DWELL_CYCLES > HOLD_CYCLES) ? DWELL_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(N_SRC - 1);

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   cur_src_q, cur_src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic [31:0]        disp_value_q, disp_value_d;
  logic               disp_valid_q, disp_valid_d;
  logic [31:0]        shadow_q [N_SRC];
  logic [31:0]        shadow_d [N_SRC];

  logic [SRC_W-1:0]   rot_next_idx, first_en_idx, first_pend_idx;
  logic               rot_found, first_en_found, any_pend;
  logic [N_SRC-1:0]   en_shifted;
  logic               cur_en;
  logic               enter_hold;

  // Next enabled source after the one currently shown (rotation step).
  rr_next_index #(.N(N_SRC), .W(SRC_W)) u_rot_next (
    .mask     (SRC_EN),
    .cur      (cur_src_q),
    .next_idx (rot_next_idx),
    .found    (rot_found)
  );

  // Lowest enabled source, used when rotation starts from idle.
  rr_next_index #(.N(N_SRC), .W(SRC_W)) u_first_en (
    .mask     (SRC_EN),
    .cur      (LAST_IDX),
    .next_idx (first_en_idx),
    .found    (first_en_found)
  );

  // Lowest pending urgent request; urgent holds are served in ascending index.
  rr_next_index #(.N(N_SRC), .W(SRC_W)) u_first_pend (
    .mask     (pending_q),
    .cur      (LAST_IDX),
    .next_idx (first_pend_idx),
    .found    (any_pend)
  );

  assign en_shifted = SRC_EN >> cur_src_q;
  assign cur_en     = en_shifted[0];

  // Scheduler FSM. Pending urgent requests preempt a dwell but never cut a
  // hold short; a hold that ends looks at the queue before resuming rotation.
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    cnt_d      = cnt_q;
    enter_hold = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          enter_hold = 1'b1;
        end else if (first_en_found) begin
          state_d   = SHOW;
          cur_src_d = first_en_idx;
          cnt_d     = '0;
        end
      end
      SHOW: begin
        if (any_pend) begin
          enter_hold = 1'b1;
        end else if (!rot_found) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!cur_en || cnt_q == DWELL_LAST) begin
          cur_src_d = rot_next_idx;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (any_pend) begin
            enter_hold = 1'b1;
          end else if (rot_found) begin
            state_d   = SHOW;
            cur_src_d = rot_next_idx;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (enter_hold) begin
      state_d   = HOLD;
      cur_src_d = first_pend_idx;
      cnt_d     = '0;
    end
  end

  // Pending flags: new urgent pulses are OR-ed in, and the source that is
  // entering its hold this cycle drops its flag (a same-cycle repeat is lost).
  always_comb begin
    pending_d = pending_q | SRC_URGENT;
    if (enter_hold) begin
      pending_d = pending_d & ~(N_SRC'(1) << first_pend_idx);
    end
  end

  // Shadow registers latch on VALID regardless of enable or state.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      shadow_d[i] = shadow_q[i];
      if (SRC_VALID[i]) begin
        shadow_d[i] = sat_value(SRC_VALUE[32*i +: 32], MAX_DISPLAY);
      end
    end
    ack_d        = SRC_VALID;
    disp_value_d = shadow_q[cur_src_q];
    disp_valid_d = (state_d != IDLE);
  end

  // All state and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cur_src_q    <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      ack_q        <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      for (int i = 0; i < N_SRC; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign SRC_ACK    = ack_q;
  assign DISP_VALUE = disp_value_q;
  assign DISP_SRC   = cur_src_q;
  assign DISP_VALID = disp_valid_q;

endmodule

// File: tb/tb_score_display_scheduler.sv
// Testbench for score_display_scheduler (N_SRC=3, dwell 4, hold 6).
// Directed scenarios check against hand-derived constants; a randomized run
// checks every cycle against a behavioural model of the scheduling rules.
module tb_score_display_scheduler;

  localparam int          N    = 3;
  localparam int          DW   = 4;
  localparam int          HD   = 6;
  localparam logic [31:0] MAXD = 32'd99_999_999;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic [N-1:0]  src_en     = '0;
  logic [N-1:0]  src_valid  = '0;
  logic [95:0]   src_value  = '0;
  logic [N-1:0]  src_urgent = '0;
  logic [N-1:0]  src_ack;
  logic [31:0]   disp_value;
  logic [1:0]    disp_src;
  logic          disp_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display_scheduler #(
    .N_SRC        (N),
    .DWELL_CYCLES (DW),
    .HOLD_CYCLES  (HD)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .SRC_EN     (src_en),
    .SRC_VALID  (src_valid),
    .SRC_VALUE  (src_value),
    .SRC_URGENT (src_urgent),
    .SRC_ACK    (src_ack),
    .DISP_VALUE (disp_value),
    .DISP_SRC   (disp_src),
    .DISP_VALID (disp_valid)
  );

  // Behavioural model: mode 0 = blank, 1 = rotating, 2 = urgent hold.
  // m_left counts the cycles still owed to the current source.
  logic [31:0]  m_shadow [N];
  logic [N-1:0] m_pend  = '0;
  int           m_mode  = 0;
  int           m_shown = 0;
  int           m_left  = 0;
  logic [31:0]  m_value = '0;
  logic [N-1:0] m_ack   = '0;
  int           nm, ns, nl, grant;
  logic [31:0]  v;

  function automatic int lowest(input logic [N-1:0] bits);
    for (int i = 0; i < N; i++) if (((bits >> i) & 3'b001) != 0) return i;
    return -1;
  endfunction

  function automatic int after(input logic [N-1:0] bits, input int from);
    for (int k = 1; k <= N; k++) begin
      if (((bits >> ((from + k) % N)) & 3'b001) != 0) return (from + k) % N;
    end
    return from;
  endfunction

  initial for (int i = 0; i < N; i++) m_shadow[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_shadow[i] = '0;
      m_pend = '0; m_mode = 0; m_shown = 0; m_left = 0; m_value = '0; m_ack = '0;
    end else begin
      m_value = m_shadow[m_shown[1:0]];
      m_ack   = src_valid;
      nm = m_mode; ns = m_shown; nl = m_left; grant = -1;
      if (m_mode == 0) begin
        if (m_pend != 0) grant = lowest(m_pend);
        else if (src_en != 0) begin nm = 1; ns = lowest(src_en); nl = DW; end
      end else if (m_mode == 1) begin
        if (m_pend != 0) grant = lowest(m_pend);
        else if (src_en == 0) nm = 0;
        else if (((src_en >> m_shown) & 3'b001) == 0 || m_left == 1) begin
          ns = after(src_en, m_shown); nl = DW;
        end else nl = m_left - 1;
      end else begin
        if (m_left == 1) begin
          if (m_pend != 0) grant = lowest(m_pend);
          else if (src_en != 0) begin nm = 1; ns = after(src_en, m_shown); nl = DW; end
          else nm = 0;
        end else nl = m_left - 1;
      end
      m_pend = m_pend | src_urgent;
      if (grant >= 0) begin
        nm = 2; ns = grant; nl = HD;
        m_pend = m_pend & ~(3'b001 << grant);
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i]) begin
          v = src_value[32*i +: 32];
          m_shadow[i] = (v > MAXD) ? MAXD : v;
        end
      end
      m_mode = nm; m_shown = ns; m_left = nl;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; src_en = 3'b111; src_valid = 3'b111; src_urgent = 3'b111;
    src_value = {96{1'b1}};
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", disp_valid); end
      checks++;
      if (disp_value !== 32'd0) begin errors++; $display("[TB] FAIL reset_value: got %0d expected 0", disp_value); end
      checks++;
      if (src_ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", src_ack); end
    end
    rst = 1'b0; src_en = '0; src_valid = '0; src_urgent = '0; src_value = '0;
    step();
    checks++;
    if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_pending: got %0b expected 0", disp_valid); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_src;
    src_valid = 3'b111;
    src_value = {32'd30, 32'd20, 32'd10};
    step();
    checks++;
    if (src_ack !== 3'b111) begin errors++; $display("[TB] FAIL rotation_ack: got %b expected 111", src_ack); end
    src_valid = '0;
    src_en = 3'b111;
    step();
    for (int j = 0; j < 16; j++) begin
      exp_src = 2'((j / 4) % 3);
      checks++;
      if (disp_valid !== 1'b1 || disp_src !== exp_src) begin
        errors++; $display("[TB] FAIL rotation_src cycle %0d: got %0d/%0b expected %0d/1", j, disp_src, disp_valid, exp_src);
      end
      if (j % 4 != 0) begin
        checks++;
        if (disp_value !== 32'(10 * (exp_src + 1))) begin
          errors++; $display("[TB] FAIL rotation_value cycle %0d: got %0d expected %0d", j, disp_value, 10 * (exp_src + 1));
        end
      end
      step();
    end
    src_en = '0;
    step();
    checks++;
    if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rotation_idle: got %0b expected 0", disp_valid); end
  endtask

  task automatic test_skip_disable();
    logic [1:0] exp_src;
    src_en = 3'b101;
    step();
    for (int j = 0; j < 15; j++) begin
      exp_src = 2'(((j / 4) % 2) * 2);
      checks++;
      if (disp_valid !== 1'b1 || disp_src !== exp_src) begin
        errors++; $display("[TB] FAIL skip_src cycle %0d: got %0d expected %0d", j, disp_src, exp_src);
      end
      if (j < 14) step();
    end
    src_en = 3'b001;
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_src !== 2'd0) begin
      errors++; $display("[TB] FAIL disable_advance: got %0d expected 0", disp_src);
    end
    src_en = '0;
    step();
    checks++;
    if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL disable_idle: got %0b expected 0", disp_valid); end
  endtask

  task automatic test_saturation();
    logic [31:0] in_tab  [4] = '{32'd5, 32'd100_000_000, 32'd7, 32'd99_999_999};
    logic [31:0] exp_tab [4] = '{32'd5, MAXD, 32'd7, MAXD};
    src_valid = 3'b001; src_value = {64'd0, 32'hFFFF_FFFF};
    step();
    checks++;
    if (src_ack !== 3'b001) begin errors++; $display("[TB] FAIL sat_ack: got %b expected 001", src_ack); end
    src_valid = '0; src_en = 3'b001;
    step();
    step();
    checks++;
    if (disp_value !== MAXD) begin errors++; $display("[TB] FAIL sat_all_ones: got %0d expected %0d", disp_value, MAXD); end
    for (int t = 0; t < 4; t++) begin
      src_valid = 3'b001; src_value = {64'd0, in_tab[t]};
      step();
      checks++;
      if (src_ack !== 3'b001) begin errors++; $display("[TB] FAIL sat_ack_%0d: got %b expected 001", t, src_ack); end
      src_valid = '0;
      step();
      checks++;
      if (src_ack !== 3'b000) begin errors++; $display("[TB] FAIL sat_ack_pulse_%0d: got %b expected 000", t, src_ack); end
      checks++;
      if (disp_value !== exp_tab[t]) begin
        errors++; $display("[TB] FAIL sat_value_%0d: got %0d expected %0d", t, disp_value, exp_tab[t]);
      end
    end
    src_en = '0;
    step();
  endtask

  task automatic test_urgent();
    logic [1:0] exp_src;
    src_valid = 3'b111; src_value = {32'd30, 32'd20, 32'd10};
    step();
    src_valid = '0; src_en = 3'b111;
    step();
    step();
    src_urgent = 3'b110;
    step();
    src_urgent = '0;
    checks++;
    if (disp_src !== 2'd0) begin errors++; $display("[TB] FAIL urgent_latency: got %0d expected 0", disp_src); end
    step();
    for (int k = 0; k < 23; k++) begin
      if (k < 12)      exp_src = 2'd1;
      else if (k < 18) exp_src = 2'd2;
      else if (k < 22) exp_src = 2'd0;
      else             exp_src = 2'd1;
      checks++;
      if (disp_valid !== 1'b1 || disp_src !== exp_src) begin
        errors++; $display("[TB] FAIL urgent_src cycle %0d: got %0d expected %0d", k, disp_src, exp_src);
      end
      if ((k < 18 && k % 6 != 0) || (k > 18 && k < 22)) begin
        checks++;
        if (disp_value !== 32'(10 * (exp_src + 1))) begin
          errors++; $display("[TB] FAIL urgent_value cycle %0d: got %0d expected %0d", k, disp_value, 10 * (exp_src + 1));
        end
      end
      src_urgent = (k == 2) ? 3'b010 : 3'b000;
      step();
    end
    src_urgent = '0; src_en = '0;
    step();
    checks++;
    if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL urgent_idle: got %0b expected 0", disp_valid); end
  endtask

  task automatic test_mid_reset();
    src_en = '0; src_urgent = 3'b110;
    step();
    src_urgent = '0;
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_src !== 2'd1) begin
      errors++; $display("[TB] FAIL midrst_hold: got %0d/%0b expected 1/1", disp_src, disp_valid);
    end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (disp_valid !== 1'b0 || disp_value !== 32'd0 || src_ack !== 3'b000) begin
      errors++; $display("[TB] FAIL midrst_clear: got valid %0b value %0d expected 0 0", disp_valid, disp_value);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_hold cycle %0d: got %0b expected 0", c, disp_valid); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (disp_valid !== (m_mode != 0)) begin
        errors++; $display("[TB] FAIL rand_valid cycle %0d: got %0b expected %0b", c, disp_valid, m_mode != 0);
      end
      checks++;
      if (src_ack !== m_ack) begin errors++; $display("[TB] FAIL rand_ack cycle %0d: got %b expected %b", c, src_ack, m_ack); end
      if (m_mode != 0) begin
        checks++;
        if (disp_src !== m_shown[1:0]) begin
          errors++; $display("[TB] FAIL rand_src cycle %0d: got %0d expected %0d", c, disp_src, m_shown);
        end
        checks++;
        if (disp_value !== m_value) begin
          errors++; $display("[TB] FAIL rand_value cycle %0d: got %0d expected %0d", c, disp_value, m_value);
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) src_en = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        src_valid[i] = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
          0: src_value[32*i +: 32] = MAXD;
          1: src_value[32*i +: 32] = MAXD + 32'd1;
          2: src_value[32*i +: 32] = 32'hFFFF_FFFF;
          default: src_value[32*i +: 32] = 32'($urandom_range(0, 1000));
        endcase
      end
      src_urgent = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step();
    end
    rst = 1'b0; src_valid = '0; src_urgent = '0; src_en = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_rotation();
    test_skip_disable();
    test_saturation();
    test_urgent();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
